// File: rtl/id_decode_queue_pkg.sv
// Shared RV32I(+M) decode definitions: opcodes, funct fields, ALU codes, decoded bundle.
package id_decode_queue_pkg;

  // Major opcodes
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcMiscMem = 7'b0001111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

  // funct3 values for OP / OP-IMM
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  // funct7 values; F7MulDiv selects the M-extension group
  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  // Fully-specified SYSTEM encodings
  localparam logic [31:0] InstEcall  = 32'h0000_0073;
  localparam logic [31:0] InstEbreak = 32'h0010_0073;
  localparam logic [31:0] InstMret   = 32'h3020_0073;

  // Memory access sizes
  localparam logic [1:0] MemByte = 2'd0;
  localparam logic [1:0] MemHalf = 2'd1;
  localparam logic [1:0] MemWord = 2'd2;

  typedef enum logic [4:0] {
    AluAdd    = 5'd0,
    AluSub    = 5'd1,
    AluAnd    = 5'd2,
    AluOr     = 5'd3,
    AluXor    = 5'd4,
    AluSll    = 5'd5,
    AluSrl    = 5'd6,
    AluSra    = 5'd7,
    AluSlt    = 5'd8,
    AluSltu   = 5'd9,
    AluMul    = 5'd10,
    AluMulh   = 5'd11,
    AluMulhsu = 5'd12,
    AluMulhu  = 5'd13,
    AluDiv    = 5'd14,
    AluDivu   = 5'd15,
    AluRem    = 5'd16,
    AluRemu   = 5'd17
  } alu_op_e;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        portb_sel;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        auipc;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        illegal;
  } decode_bundle_t;

  function automatic logic [31:0] gen_imm(input imm_sel_e sel, input logic [31:0] inst);
    logic [31:0] imm;
    unique case (sel)
      ImmI:    imm = {{20{inst[31]}}, inst[31:20]};
      ImmS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      ImmB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      ImmU:    imm = {inst[31:12], 12'b0};
      ImmJ:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

  // Base integer ALU op from funct3; alt (funct7[5]) only distinguishes SRA from SRL
  function automatic alu_op_e base_alu(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    unique case (f3)
      F3AddSub: op = AluAdd;
      F3Sll:    op = AluSll;
      F3Slt:    op = AluSlt;
      F3Sltu:   op = AluSltu;
      F3Xor:    op = AluXor;
      F3SrlSra: op = alt ? AluSra : AluSrl;
      F3Or:     op = AluOr;
      default:  op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_decode_queue_if.sv
// Fetch-side and execute-side signals of the decode queue.
interface id_decode_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [31:0]     in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [31:0]     out_imm;
  logic [4:0]      out_alu_op;
  logic            out_portb_sel;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic [1:0]      out_mem_size;
  logic            out_mem_unsigned;
  logic            out_branch;
  logic            out_jal;
  logic            out_jalr;
  logic            out_lui;
  logic            out_auipc;
  logic            out_ecall;
  logic            out_ebreak;
  logic            out_mret;
  logic            out_illegal;
  logic [CntW-1:0] occupancy;

  // Queue side
  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op,
           out_portb_sel, out_reg_write, out_mem_read, out_mem_write, out_mem_size,
           out_mem_unsigned, out_branch, out_jal, out_jalr, out_lui, out_auipc, out_ecall,
           out_ebreak, out_mret, out_illegal, occupancy
  );

  // Pipeline side (fetch + execute)
  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op,
           out_portb_sel, out_reg_write, out_mem_read, out_mem_write, out_mem_size,
           out_mem_unsigned, out_branch, out_jal, out_jalr, out_lui, out_auipc, out_ecall,
           out_ebreak, out_mret, out_illegal, occupancy
  );
endinterface

// File: rtl/rv32_decode_core.sv
// Purely combinational RV32I(+M) instruction decoder producing one decode bundle.
module rv32_decode_core
  import id_decode_queue_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0]    inst_i,
  output decode_bundle_t bundle_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  // Decode opcode/funct fields into controls, then squash controls if illegal
  always_comb begin
    decode_bundle_t b;
    imm_sel_e       imm_sel;
    logic           legal;
    logic           writes_rd;

    b         = '0;
    imm_sel   = ImmNone;
    legal     = 1'b1;
    writes_rd = 1'b0;
    b.rs1     = inst_i[19:15];
    b.rs2     = inst_i[24:20];
    b.rd      = inst_i[11:7];

    case (opcode)
      OpcLui: begin
        imm_sel     = ImmU;
        b.lui       = 1'b1;
        b.portb_sel = 1'b1;
        writes_rd   = 1'b1;
      end
      OpcAuipc: begin
        imm_sel     = ImmU;
        b.auipc     = 1'b1;
        b.portb_sel = 1'b1;
        writes_rd   = 1'b1;
      end
      OpcJal: begin
        imm_sel   = ImmJ;
        b.jal     = 1'b1;
        writes_rd = 1'b1;
      end
      OpcJalr: begin
        legal       = (funct3 == 3'b000);
        imm_sel     = ImmI;
        b.jalr      = 1'b1;
        b.portb_sel = 1'b1;
        writes_rd   = 1'b1;
      end
      OpcBranch: begin
        legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
        imm_sel  = ImmB;
        b.branch = 1'b1;
        b.alu_op = AluSub;
      end
      OpcLoad: begin
        // LB/LH/LW/LBU/LHU only
        legal          = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        imm_sel        = ImmI;
        b.mem_read     = 1'b1;
        b.portb_sel    = 1'b1;
        b.mem_size     = funct3[1:0];
        b.mem_unsigned = funct3[2];
        writes_rd      = 1'b1;
      end
      OpcStore: begin
        legal       = !funct3[2] && (funct3 != 3'b011);
        imm_sel     = ImmS;
        b.mem_write = 1'b1;
        b.portb_sel = 1'b1;
        b.mem_size  = funct3[1:0];
      end
      OpcOpImm: begin
        // Shift-immediates reuse funct7 as an encoding field; others use it as immediate bits
        if (funct3 == F3Sll) begin
          legal = (funct7 == F7Base);
        end else if (funct3 == F3SrlSra) begin
          legal = (funct7 == F7Base) || (funct7 == F7Alt);
        end
        imm_sel     = ImmI;
        b.alu_op    = base_alu(funct3, funct7[5]);
        b.portb_sel = 1'b1;
        writes_rd   = 1'b1;
      end
      OpcOp: begin
        writes_rd = 1'b1;
        if (funct7 == F7MulDiv) begin
          legal    = ENABLE_M;
          b.alu_op = alu_op_e'({2'b00, funct3} + 5'(AluMul));
        end else if (funct7 == F7Base) begin
          b.alu_op = base_alu(funct3, 1'b0);
        end else if (funct7 == F7Alt && funct3 == F3AddSub) begin
          b.alu_op = AluSub;
        end else if (funct7 == F7Alt && funct3 == F3SrlSra) begin
          b.alu_op = AluSra;
        end else begin
          legal = 1'b0;
        end
      end
      OpcMiscMem: begin
        // FENCE is a no-op in this in-order pipeline
        legal = (funct3 == 3'b000);
      end
      OpcSystem: begin
        if (funct3 == 3'b000) begin
          if (inst_i == InstEcall) begin
            b.ecall = 1'b1;
          end else if (inst_i == InstEbreak) begin
            b.ebreak = 1'b1;
          end else if (inst_i == InstMret) begin
            b.mret = 1'b1;
          end else begin
            legal = 1'b0;
          end
        end else if (funct3 == 3'b100) begin
          legal = 1'b0;
        end
        // Remaining funct3 values are CSR ops, passed on without controls
      end
      default: legal = 1'b0;
    endcase

    b.imm       = gen_imm(imm_sel, inst_i);
    b.reg_write = writes_rd && (b.rd != 5'd0);

    if (!legal) begin
      b         = '0;
      b.rs1     = inst_i[19:15];
      b.rs2     = inst_i[24:20];
      b.rd      = inst_i[11:7];
      b.illegal = 1'b1;
    end

    bundle_o = b;
  end

endmodule

// File: rtl/id_decode_queue.sv
// Decode stage: decodes fetched instructions and buffers bundles in a DEPTH-entry FIFO.
module id_decode_queue
  import id_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter bit          ENABLE_M = 1'b0
) (
  input logic              clk,
  input logic              rst,
  id_decode_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [31:0]    pc;
    decode_bundle_t bundle;
  } entry_t;

  decode_bundle_t  dec_bundle;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  entry_t          head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            in_ready;
  logic            out_valid;
  logic            push;
  logic            pop;

  rv32_decode_core #(
    .ENABLE_M(ENABLE_M)
  ) u_decode_core (
    .inst_i  (bus.in_inst),
    .bundle_o(dec_bundle)
  );

  // Full/empty come from the count so pointer equality never needs disambiguating
  assign in_ready  = (count_q < CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid && in_ready && !bus.flush;
  assign pop       = out_valid && bus.out_ready && !bus.flush;

  // Next-state for storage, pointers and count; flush overrides push and pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: bus.in_pc, bundle: dec_bundle};
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // State registers with asynchronous clear of pointers, count and storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Head entry, forced to zero when the queue is empty
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign bus.in_ready         = in_ready;
  assign bus.out_valid        = out_valid;
  assign bus.occupancy        = count_q;
  assign bus.out_pc           = head.pc;
  assign bus.out_rs1          = head.bundle.rs1;
  assign bus.out_rs2          = head.bundle.rs2;
  assign bus.out_rd           = head.bundle.rd;
  assign bus.out_imm          = head.bundle.imm;
  assign bus.out_alu_op       = head.bundle.alu_op;
  assign bus.out_portb_sel    = head.bundle.portb_sel;
  assign bus.out_reg_write    = head.bundle.reg_write;
  assign bus.out_mem_read     = head.bundle.mem_read;
  assign bus.out_mem_write    = head.bundle.mem_write;
  assign bus.out_mem_size     = head.bundle.mem_size;
  assign bus.out_mem_unsigned = head.bundle.mem_unsigned;
  assign bus.out_branch       = head.bundle.branch;
  assign bus.out_jal          = head.bundle.jal;
  assign bus.out_jalr         = head.bundle.jalr;
  assign bus.out_lui          = head.bundle.lui;
  assign bus.out_auipc        = head.bundle.auipc;
  assign bus.out_ecall        = head.bundle.ecall;
  assign bus.out_ebreak       = head.bundle.ebreak;
  assign bus.out_mret         = head.bundle.mret;
  assign bus.out_illegal      = head.bundle.illegal;

endmodule

// File: tb/tb_id_decode_queue.sv
// Directed self-checking bench for id_decode_queue (ENABLE_M=0 and ENABLE_M=1 instances).
module tb_id_decode_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  id_decode_queue_if #(.DEPTH(4)) b ();
  id_decode_queue_if #(.DEPTH(4)) bm ();

  id_decode_queue #(.DEPTH(4), .ENABLE_M(1'b0)) dut (.clk(clk), .rst(rst), .bus(b));
  id_decode_queue #(.DEPTH(4), .ENABLE_M(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bm));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    b.in_valid = v;
    b.in_inst  = inst;
    b.in_pc    = pc;
  endtask

  // {illegal, reg_write, mem_read, mem_write, mem_size, mem_unsigned,
  //  branch, jal, jalr, lui, auipc, ecall, portb_sel}
  function automatic logic [13:0] flags;
    return {b.out_illegal, b.out_reg_write, b.out_mem_read, b.out_mem_write, b.out_mem_size,
            b.out_mem_unsigned, b.out_branch, b.out_jal, b.out_jalr, b.out_lui, b.out_auipc,
            b.out_ecall, b.out_portb_sel};
  endfunction

  // addi x1, x0, k
  function automatic logic [31:0] addi_imm(input int k);
    return {12'(k), 20'h00093};
  endfunction

  // addi, sub, srai, lw, sw, jal, ecall, fence, unknown opcode
  logic [31:0] vec_inst [9] = '{32'h00500093, 32'h402081B3, 32'h40335293, 32'h00812203,
                                32'h00512623, 32'h010000EF, 32'h00000073, 32'h0FF0000F,
                                32'hFFFFFFFF};
  logic [31:0] vec_imm  [9] = '{32'd5, 32'd0, 32'h403, 32'd8, 32'd12, 32'd16, 32'd0, 32'd0,
                                32'd0};
  logic [4:0]  vec_alu  [9] = '{5'd0, 5'd1, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [13:0] vec_flags[9] = '{14'b01000000000001, 14'b01000000000000, 14'b01000000000001,
                                14'b01101000000001, 14'b00011000000001, 14'b01000000100000,
                                14'b00000000000010, 14'b00000000000000, 14'b10000000000000};

  initial begin
    drive(1'b0, 32'h0, 32'h0);
    b.flush      = 1'b0;
    b.out_ready  = 1'b0;
    bm.in_valid  = 1'b0;
    bm.in_inst   = 32'h0;
    bm.in_pc     = 32'h0;
    bm.flush     = 1'b0;
    bm.out_ready = 1'b0;

    // Reset state
    tick;
    tick;
    check_eq("rst_occ", 32'(b.occupancy), 32'd0);
    check_eq("rst_out_valid", 32'(b.out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(b.in_ready), 32'd1);
    check_eq("rst_out_pc", b.out_pc, 32'd0);
    rst = 1'b0;
    tick;

    // addi x1,x0,5: visible one cycle after push, then popped
    b.out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 32'h100);
    tick;
    drive(1'b0, 32'h0, 32'h0);
    check_eq("addi_valid", 32'(b.out_valid), 32'd1);
    check_eq("addi_rd", 32'(b.out_rd), 32'd1);
    check_eq("addi_rs1", 32'(b.out_rs1), 32'd0);
    check_eq("addi_imm", b.out_imm, 32'd5);
    check_eq("addi_alu", 32'(b.out_alu_op), 32'd0);
    check_eq("addi_portb", 32'(b.out_portb_sel), 32'd1);
    check_eq("addi_regw", 32'(b.out_reg_write), 32'd1);
    check_eq("addi_pc", b.out_pc, 32'h100);
    tick;
    check_eq("empty_valid", 32'(b.out_valid), 32'd0);
    check_eq("empty_imm_zero", b.out_imm, 32'd0);
    check_eq("empty_regw_zero", 32'(b.out_reg_write), 32'd0);

    // lui then beq, held with out_ready low
    b.out_ready = 1'b0;
    drive(1'b1, 32'h12345137, 32'h104);
    tick;
    drive(1'b1, 32'hFE208CE3, 32'h108);
    check_eq("lui_imm", b.out_imm, 32'h12345000);
    check_eq("lui_flag", 32'(b.out_lui), 32'd1);
    check_eq("lui_regw", 32'(b.out_reg_write), 32'd1);
    check_eq("lui_rd", 32'(b.out_rd), 32'd2);
    tick;
    drive(1'b0, 32'h0, 32'h0);
    b.out_ready = 1'b1;
    tick;
    check_eq("beq_imm", b.out_imm, 32'hFFFFFFF8);
    check_eq("beq_branch", 32'(b.out_branch), 32'd1);
    check_eq("beq_alu", 32'(b.out_alu_op), 32'd1);
    check_eq("beq_regw", 32'(b.out_reg_write), 32'd0);
    check_eq("beq_rs1", 32'(b.out_rs1), 32'd1);
    check_eq("beq_rs2", 32'(b.out_rs2), 32'd2);
    check_eq("beq_pc", b.out_pc, 32'h108);
    tick;

    // Decode table, one instruction at a time
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, vec_inst[k], 32'(32'h1000 + k * 4));
      tick;
      drive(1'b0, 32'h0, 32'h0);
      check_eq($sformatf("vec%0d_pc", k), b.out_pc, 32'(32'h1000 + k * 4));
      check_eq($sformatf("vec%0d_imm", k), b.out_imm, vec_imm[k]);
      check_eq($sformatf("vec%0d_alu", k), 32'(b.out_alu_op), 32'(vec_alu[k]));
      check_eq($sformatf("vec%0d_flags", k), 32'(flags()), 32'(vec_flags[k]));
      tick;
    end

    // Fill to DEPTH with a fifth pending
    b.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, addi_imm(k), 32'(32'h200 + k * 4));
      tick;
    end
    drive(1'b1, addi_imm(4), 32'h210);
    check_eq("full_occ", 32'(b.occupancy), 32'd4);
    check_eq("full_in_ready", 32'(b.in_ready), 32'd0);
    check_eq("full_head_pc", b.out_pc, 32'h200);
    tick;
    check_eq("full_held_occ", 32'(b.occupancy), 32'd4);
    b.out_ready = 1'b1;
    tick;
    check_eq("pop0_occ", 32'(b.occupancy), 32'd3);
    check_eq("pop0_pc", b.out_pc, 32'h204);
    check_eq("pop0_imm", b.out_imm, 32'd1);
    tick;
    drive(1'b0, 32'h0, 32'h0);
    check_eq("pop1_occ", 32'(b.occupancy), 32'd3);
    check_eq("pop1_pc", b.out_pc, 32'h208);
    tick;
    check_eq("pop2_pc", b.out_pc, 32'h20C);
    tick;
    check_eq("fifth_pc", b.out_pc, 32'h210);
    check_eq("fifth_imm", b.out_imm, 32'd4);
    check_eq("fifth_occ", 32'(b.occupancy), 32'd1);
    tick;
    check_eq("drained_occ", 32'(b.occupancy), 32'd0);

    // Simultaneous push and pop at occupancy 2, across pointer wrap
    b.out_ready = 1'b0;
    drive(1'b1, addi_imm(10), 32'h300);
    tick;
    drive(1'b1, addi_imm(11), 32'h304);
    tick;
    check_eq("pp_occ_start", 32'(b.occupancy), 32'd2);
    b.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, addi_imm(12 + k), 32'(32'h308 + k * 4));
      tick;
      check_eq($sformatf("pp%0d_occ", k), 32'(b.occupancy), 32'd2);
      check_eq($sformatf("pp%0d_pc", k), b.out_pc, 32'(32'h304 + k * 4));
    end
    drive(1'b0, 32'h0, 32'h0);
    tick;
    check_eq("pp_tail_pc", b.out_pc, 32'h310);
    tick;

    // mul x3,x1,x2 on both configurations
    b.out_ready  = 1'b0;
    drive(1'b1, 32'h022081B3, 32'h600);
    bm.in_valid  = 1'b1;
    bm.in_inst   = 32'h022081B3;
    bm.in_pc     = 32'h600;
    tick;
    drive(1'b0, 32'h0, 32'h0);
    bm.in_valid  = 1'b0;
    check_eq("mul_nom_illegal", 32'(b.out_illegal), 32'd1);
    check_eq("mul_nom_regw", 32'(b.out_reg_write), 32'd0);
    check_eq("mul_m_illegal", 32'(bm.out_illegal), 32'd0);
    check_eq("mul_m_alu", 32'(bm.out_alu_op), 32'd10);
    check_eq("mul_m_regw", 32'(bm.out_reg_write), 32'd1);
    check_eq("mul_m_rd", 32'(bm.out_rd), 32'd3);
    b.out_ready  = 1'b1;
    bm.out_ready = 1'b1;
    tick;
    b.out_ready  = 1'b0;

    // Flush with a same-cycle push
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, addi_imm(20 + k), 32'(32'h400 + k * 4));
      tick;
    end
    check_eq("flush_pre_occ", 32'(b.occupancy), 32'd3);
    drive(1'b1, addi_imm(99), 32'h40C);
    b.flush = 1'b1;
    tick;
    b.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check_eq("flush_occ", 32'(b.occupancy), 32'd0);
    check_eq("flush_valid", 32'(b.out_valid), 32'd0);
    check_eq("flush_in_ready", 32'(b.in_ready), 32'd1);
    tick;
    check_eq("flush_still_empty", 32'(b.occupancy), 32'd0);
    drive(1'b1, addi_imm(7), 32'h500);
    tick;
    drive(1'b1, addi_imm(8), 32'h504);
    check_eq("post_flush_pc", b.out_pc, 32'h500);
    check_eq("post_flush_occ", 32'(b.occupancy), 32'd1);
    tick;
    drive(1'b1, addi_imm(9), 32'h508);
    tick;
    drive(1'b0, 32'h0, 32'h0);
    check_eq("pre_rst_occ", 32'(b.occupancy), 32'd3);

    // Asynchronous reset mid-stream, sampled before any clock edge
    #1 rst = 1'b1;
    #1;
    check_eq("arst_occ", 32'(b.occupancy), 32'd0);
    check_eq("arst_valid", 32'(b.out_valid), 32'd0);
    check_eq("arst_pc", b.out_pc, 32'd0);
    rst = 1'b0;
    tick;
    check_eq("arst_after_occ", 32'(b.occupancy), 32'd0);
    check_eq("arst_after_ready", 32'(b.in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_decode_queue.md
# id_decode_queue

Parametrised RV32I(+M) decode stage for the Titan pipeline: sits between fetch and execute, accepts raw instructions with their PC over a valid/ready handshake, decodes them, and buffers the decoded bundles in a DEPTH-entry FIFO. It extends single-instruction combinational decode with back-pressure, flush, illegal-instruction detection, corrected U/J/B immediates and optional M-extension decode. Execute pops one decoded bundle per handshake.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ENABLE_M, 0: 1 = decode MUL/DIV/REM group; 0 = those encodings flag illegal.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  queue can accept; `occupancy < DEPTH`.
- in_inst  in  32  raw instruction.
- in_pc  in  32  instruction address.
- flush  in  1  discard all entries and any same-cycle push.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes head.
- out_pc  out  32  PC of head.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  32  sign-extended immediate.
- out_alu_op  out  5  ALU operation code.
- out_portb_sel  out  1  1 = ALU port B takes immediate.
- out_reg_write, out_mem_read, out_mem_write  out  1 each.
- out_mem_size  out  2  0 byte, 1 half, 2 word.
- out_mem_unsigned  out  1  LBU/LHU.
- out_branch, out_jal, out_jalr, out_lui, out_auipc  out  1 each.
- out_ecall, out_ebreak, out_mret, out_illegal  out  1 each.
- occupancy  out  $clog2(DEPTH)+1  entries held.

## Operation
- Push when `in_valid && in_ready && !flush`: in_inst decoded combinationally, bundle written at write pointer.
- Pop when `out_valid && out_ready`; push and pop in the same cycle allowed, occupancy unchanged. No push while full, even if popping that cycle.
- All out_* decoded fields driven 0 whenever out_valid=0.
- Immediates: I/load/JALR = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); U = {inst[31:12],12'b0}; J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); R-type 0.
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17. Loads/stores/LUI/AUIPC/JAL/JALR use ADD; branches SUB; SRAI/SRA → 7, SRLI/SRL → 6.
- portb_sel=1 for OP-IMM, loads, stores, JALR, LUI, AUIPC.
- reg_write=1 for OP, OP-IMM, loads, LUI, AUIPC, JAL, JALR, and rd≠0; else 0.
- Illegal: unknown opcode, undefined funct3/funct7 combination, M-group with ENABLE_M=0, SYSTEM not ECALL/EBREAK/MRET/CSR. Illegal bundle: out_illegal=1, all write/mem/branch/jump controls 0.
- FENCE decodes as legal no-op (all controls 0).

## Timing
- Reset: occupancy 0, pointers 0, out_valid 0, in_ready 1, all out_* 0, storage cleared.
- Latency: instruction pushed in cycle N is visible at the head in N+1 if queue was empty.
- Flush: takes effect at the edge; next cycle occupancy 0, out_valid 0; same-cycle push discarded; flush has priority over push and pop.
- Pointers wrap modulo DEPTH; full/empty from occupancy, not pointer compare.
- Reset mid-operation: immediate asynchronous clear, identical to reset values.
- Outputs come from registered storage; no in→out combinational path except in_ready depending only on occupancy.

## Structure
- Shared definitions file (extends def.v): opcode, funct3, funct7 constants, M-group funct7, ALU code constants, mem_size codes.
- Sub-module `rv32_decode_core`: purely combinational inst→bundle decoder (immediate, controls, illegal), reusable by a future dual-issue stage. Queue logic stays in `id_decode_queue`.

## Test plan
- Push 0x00500093 (addi x1,x0,5), pc 0x100, out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_op 0, portb_sel=1, reg_write=1, out_pc 0x100.
- Push 0x12345137 (lui x2,0x12345) → imm 0x12345000, lui=1, reg_write=1; push 0xFE208CE3 (beq x1,x2,-8) → imm 0xFFFFFFF8, branch=1, alu_op 1, reg_write=0.
- DEPTH=4, out_ready=0, push 5 back-to-back → in_ready=0 after 4th accept, occupancy 4; 5th held; raise out_ready → four pops in push order, then 5th accepted.
- Push 0x022081B3 (mul x3,x1,x2): ENABLE_M=0 → out_illegal=1, reg_write=0; ENABLE_M=1 → alu_op 10, reg_write=1.
- Queue holding 3, assert flush with in_valid=1 → next cycle out_valid=0, occupancy 0, pushed instruction never appears; repeat with rst pulsed mid-stream → same result asynchronously.
- Simultaneous push and pop at occupancy 2 → occupancy stays 2, order preserved across pointer wrap.
